// File: rtl/alu_req_arbiter_if.sv
// Bundle of requester, ALU and response signals for the shared-ALU arbiter.
// Names keep their _i/_o suffixes as seen from the arbiter (slave) side.
//
// Handshake semantics (all channels): a transfer happens on the rising edge
// where valid and ready are both high. The requester presents operands with
// valid high and may change or drop them while ready is low. The arbiter
// holds every resp_* output stable while resp_valid_o is high and
// resp_ready_i is low.
interface alu_req_arbiter_if #(
   parameter int W = 32
);
   logic         req0_valid_i;
   logic         req0_ready_o;
   logic [W-1:0] req0_data1_i;
   logic [W-1:0] req0_data2_i;
   logic [2:0]   req0_op_i;
   logic         req0_type_i;

   logic         req1_valid_i;
   logic         req1_ready_o;
   logic [W-1:0] req1_data1_i;
   logic [W-1:0] req1_data2_i;
   logic [2:0]   req1_op_i;
   logic         req1_type_i;

   logic [W-1:0] alu_data1_o;
   logic [W-1:0] alu_data2_o;
   logic [2:0]   alu_ctrl_o;
   logic         alu_type_o;
   logic [W-1:0] alu_data_i;
   logic         alu_zero_i;

   logic         resp_valid_o;
   logic         resp_ready_i;
   logic         resp_id_o;
   logic [W-1:0] resp_data_o;
   logic         resp_zero_o;
   logic         resp_err_o;

   logic         busy_o;
   logic [1:0]   state_dbg_o;

   modport slave (
      input  req0_valid_i, req0_data1_i, req0_data2_i, req0_op_i, req0_type_i,
      output req0_ready_o,
      input  req1_valid_i, req1_data1_i, req1_data2_i, req1_op_i, req1_type_i,
      output req1_ready_o,
      output alu_data1_o, alu_data2_o, alu_ctrl_o, alu_type_o,
      input  alu_data_i, alu_zero_i,
      output resp_valid_o, resp_id_o, resp_data_o, resp_zero_o, resp_err_o,
      input  resp_ready_i,
      output busy_o, state_dbg_o
   );

   modport master (
      output req0_valid_i, req0_data1_i, req0_data2_i, req0_op_i, req0_type_i,
      input  req0_ready_o,
      output req1_valid_i, req1_data1_i, req1_data2_i, req1_op_i, req1_type_i,
      input  req1_ready_o,
      input  alu_data1_o, alu_data2_o, alu_ctrl_o, alu_type_o,
      output alu_data_i, alu_zero_i,
      input  resp_valid_o, resp_id_o, resp_data_o, resp_zero_o, resp_err_o,
      output resp_ready_i,
      input  busy_o, state_dbg_o
   );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters. One operation
// is in flight at a time: accept in IDLE, wait ALU_LAT+1 edges in EXEC,
// present the tagged result in RESP until the consumer takes it. Illegal
// opcodes and integer divide-by-zero skip the ALU and answer with err set.
module alu_req_arbiter #(
   parameter int ALU_LAT = 1,
   parameter int W       = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   alu_req_arbiter_if.slave bus
);
   localparam int CW = $clog2(ALU_LAT + 2);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic            last_grant_q;
   logic [CW-1:0]   cnt_q;

   logic            grant_any;
   logic            grant_id;
   logic [W-1:0]    sel_a;
   logic [W-1:0]    sel_b;
   logic [2:0]      sel_op;
   logic            sel_type;
   logic            reject;

   // Round-robin grant, only offered while idle; ties go to the non-last id.
   always_comb begin
      grant_any = 1'b0;
      grant_id  = 1'b0;
      if (state_q == IDLE) begin
         if (bus.req0_valid_i && bus.req1_valid_i) begin
            grant_any = 1'b1;
            grant_id  = ~last_grant_q;
         end else if (bus.req0_valid_i) begin
            grant_any = 1'b1;
            grant_id  = 1'b0;
         end else if (bus.req1_valid_i) begin
            grant_any = 1'b1;
            grant_id  = 1'b1;
         end
      end
   end

   assign bus.req0_ready_o = grant_any & ~grant_id;
   assign bus.req1_ready_o = grant_any &  grant_id;

   // Operand mux for the granted requester and screening of illegal ops.
   always_comb begin
      sel_a    = grant_id ? bus.req1_data1_i : bus.req0_data1_i;
      sel_b    = grant_id ? bus.req1_data2_i : bus.req0_data2_i;
      sel_op   = grant_id ? bus.req1_op_i    : bus.req0_op_i;
      sel_type = grant_id ? bus.req1_type_i  : bus.req0_type_i;
      reject   = (sel_op == 3'd0) || (sel_op > 3'd4) ||
                 (sel_type && (sel_op == 3'd4) && (sel_b == '0));
   end

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (grant_any) state_d = reject ? RESP : EXEC;
         EXEC: if (cnt_q == CW'(1)) state_d = RESP;
         RESP: if (bus.resp_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Operand launch, latency count and result capture.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_grant_q    <= 1'b1;
         cnt_q           <= '0;
         bus.alu_data1_o <= '0;
         bus.alu_data2_o <= '0;
         bus.alu_ctrl_o  <= 3'd0;
         bus.alu_type_o  <= 1'b1;
         bus.resp_id_o   <= 1'b0;
         bus.resp_data_o <= '0;
         bus.resp_zero_o <= 1'b0;
         bus.resp_err_o  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_any) begin
                  last_grant_q  <= grant_id;
                  bus.resp_id_o <= grant_id;
                  if (reject) begin
                     bus.resp_data_o <= '0;
                     bus.resp_zero_o <= 1'b0;
                     bus.resp_err_o  <= 1'b1;
                  end else begin
                     bus.alu_data1_o <= sel_a;
                     bus.alu_data2_o <= sel_b;
                     bus.alu_ctrl_o  <= sel_op;
                     bus.alu_type_o  <= sel_type;
                     cnt_q           <= CW'(ALU_LAT + 1);
                  end
               end
            end
            EXEC: begin
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  bus.resp_data_o <= bus.alu_data_i;
                  bus.resp_zero_o <= bus.alu_zero_i;
                  bus.resp_err_o  <= 1'b0;
                  // Code 0 tells the ALU to hold its output between ops.
                  bus.alu_ctrl_o  <= 3'd0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.resp_valid_o = (state_q == RESP);
   assign bus.busy_o       = (state_q != IDLE);
   assign bus.state_dbg_o  = state_q;
endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: directed table of single transactions, tie and
// backpressure sequence, mid-EXEC reset, a slow-ALU instance and a random
// run against a transaction-level reference model.
module tb_alu_req_arbiter;
  localparam int W    = 32;
  localparam int LAT1 = 1;
  localparam int LAT3 = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_req_arbiter_if #(.W(W)) b1 ();
  alu_req_arbiter_if #(.W(W)) b3 ();

  alu_req_arbiter #(.ALU_LAT(LAT1), .W(W)) dut1 (.clk_i(clk), .rst_i(rst), .bus(b1));
  alu_req_arbiter #(.ALU_LAT(LAT3), .W(W)) dut3 (.clk_i(clk), .rst_i(rst), .bus(b3));

  // Reference ALU behaviour; the FPU stand-in flips the top bit so that its
  // results are distinguishable from integer ones.
  function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] op, input logic typ);
    logic [W-1:0] r;
    r = '0;
    case (op)
      3'd1: r = a + b;
      3'd2: r = a - b;
      3'd3: r = a * b;
      3'd4: r = (b == '0) ? '0 : a / b;
      default: r = '0;
    endcase
    if (!typ) r = r ^ {1'b1, {(W-1){1'b0}}};
    return r;
  endfunction

  // ALU models: output updates LAT edges after inputs settle, holds on code 0.
  logic [W-1:0] p1 = '0;
  logic [W-1:0] p3 [3] = '{default: '0};
  always @(posedge clk) begin
    if (b1.alu_ctrl_o != 3'd0) p1 <= alu_f(b1.alu_data1_o, b1.alu_data2_o, b1.alu_ctrl_o, b1.alu_type_o);
    if (b3.alu_ctrl_o != 3'd0) begin
      p3[0] <= alu_f(b3.alu_data1_o, b3.alu_data2_o, b3.alu_ctrl_o, b3.alu_type_o);
      p3[1] <= p3[0];
      p3[2] <= p3[1];
    end
  end
  assign b1.alu_data_i = p1;
  assign b1.alu_zero_i = (p1 == '0);
  assign b3.alu_data_i = p3[2];
  assign b3.alu_zero_i = (p3[2] == '0);

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit           id;
    logic [2:0]   op;
    bit           typ;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           hold;
    logic [W-1:0] exp_d;
    bit           exp_z;
    bit           exp_e;
  } vec_t;

  vec_t vecs [12];

  task automatic set_req(input bit id, input bit v, input logic [2:0] op, input bit typ,
                         input logic [W-1:0] a, input logic [W-1:0] b);
    if (id) begin
      b1.req1_valid_i = v; b1.req1_op_i = op; b1.req1_type_i = typ;
      b1.req1_data1_i = a; b1.req1_data2_i = b;
    end else begin
      b1.req0_valid_i = v; b1.req0_op_i = op; b1.req0_type_i = typ;
      b1.req0_data1_i = a; b1.req0_data2_i = b;
    end
  endtask

  function automatic logic ready_of(input bit id);
    return id ? b1.req1_ready_o : b1.req0_ready_o;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, " busy"},      64'(b1.busy_o), 64'(0));
    check({tag, " state"},     64'(b1.state_dbg_o), 64'(0));
    check({tag, " alu_data1"}, 64'(b1.alu_data1_o), 64'(0));
    check({tag, " alu_data2"}, 64'(b1.alu_data2_o), 64'(0));
    check({tag, " alu_ctrl"},  64'(b1.alu_ctrl_o), 64'(0));
    check({tag, " alu_type"},  64'(b1.alu_type_o), 64'(1));
    check({tag, " resp_valid"},64'(b1.resp_valid_o), 64'(0));
    check({tag, " resp_id"},   64'(b1.resp_id_o), 64'(0));
    check({tag, " resp_data"}, 64'(b1.resp_data_o), 64'(0));
    check({tag, " resp_zero"}, 64'(b1.resp_zero_o), 64'(0));
    check({tag, " resp_err"},  64'(b1.resp_err_o), 64'(0));
  endtask

  // One complete transaction on dut1; lat counts cycles from the accept cycle
  // to the first cycle with resp_valid_o high.
  task automatic run_vec(input vec_t v);
    int n;
    int lat;
    logic rdy;
    @(posedge clk); #1;
    b1.resp_ready_i = 1'b0;
    set_req(v.id, 1'b1, v.op, v.typ, v.a, v.b);
    n = 0;
    do begin
      @(negedge clk); n++;
      rdy = ready_of(v.id);
    end while (!rdy && n < 20);
    check("grant", 64'(rdy), 64'(1));
    @(posedge clk); #1;
    set_req(v.id, 1'b0, v.op, v.typ, v.a, v.b);
    lat = 0;
    do begin
      @(negedge clk); lat++;
      if (lat == 1) begin
        check("alu_ctrl after accept", 64'(b1.alu_ctrl_o), v.exp_e ? 64'(0) : 64'(v.op));
        if (!v.exp_e) check("alu_type after accept", 64'(b1.alu_type_o), 64'(v.typ));
      end
    end while (!b1.resp_valid_o && lat < 20);
    check("latency", 64'(lat), v.exp_e ? 64'(1) : 64'(LAT1 + 2));
    check("resp_id",   64'(b1.resp_id_o),   64'(v.id));
    check("resp_data", 64'(b1.resp_data_o), 64'(v.exp_d));
    check("resp_zero", 64'(b1.resp_zero_o), 64'(v.exp_z));
    check("resp_err",  64'(b1.resp_err_o),  64'(v.exp_e));
    for (int h = 1; h < v.hold; h++) begin
      @(negedge clk);
      check("held valid", 64'(b1.resp_valid_o), 64'(1));
      check("held data",  64'(b1.resp_data_o),  64'(v.exp_d));
    end
    @(posedge clk); #1 b1.resp_ready_i = 1'b1;
    @(negedge clk);
    check("valid at handshake", 64'(b1.resp_valid_o), 64'(1));
    @(posedge clk); #1 b1.resp_ready_i = 1'b0;
    @(negedge clk);
    check("busy after handshake", 64'(b1.busy_o), 64'(0));
  endtask

  task automatic wait_valid1(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!b1.resp_valid_o && n < 20);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit idle;
    bit last;
    int vcyc;
    logic [W+2:0] exp_q [$];

    vecs[0]  = '{0, 3'd1, 1, 5,         7,         1, 32'd12,         0, 0};
    vecs[1]  = '{1, 3'd2, 1, 9,         9,         1, 32'd0,          1, 0};
    vecs[2]  = '{0, 3'd3, 1, 3,         4,         1, 32'd12,         0, 0};
    vecs[3]  = '{0, 3'd4, 1, 20,        4,         3, 32'd5,          0, 0};
    vecs[4]  = '{1, 3'd4, 1, 8,         0,         1, 32'd0,          0, 1};
    vecs[5]  = '{1, 3'd5, 1, 8,         2,         1, 32'd0,          0, 1};
    vecs[6]  = '{0, 3'd0, 1, 8,         2,         1, 32'd0,          0, 1};
    vecs[7]  = '{1, 3'd2, 1, 3,         5,         1, 32'hFFFF_FFFE,  0, 0};
    vecs[8]  = '{0, 3'd3, 1, 32'h10000, 32'h10000, 1, 32'd0,          1, 0};
    vecs[9]  = '{1, 3'd1, 0, 5,         7,         1, 32'h8000_000C,  0, 0};
    vecs[10] = '{0, 3'd4, 0, 8,         0,         2, 32'h8000_0000,  0, 0};
    vecs[11] = '{1, 3'd7, 0, 8,         2,         1, 32'd0,          0, 1};

    // Clock/reset and idle inputs.
    rst = 1'b1;
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    b1.resp_ready_i = 1'b0;
    b3.req0_valid_i = 0; b3.req0_op_i = 0; b3.req0_type_i = 0; b3.req0_data1_i = 0; b3.req0_data2_i = 0;
    b3.req1_valid_i = 0; b3.req1_op_i = 0; b3.req1_type_i = 0; b3.req1_data1_i = 0; b3.req1_data2_i = 0;
    b3.resp_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_vals("reset");
    check("lat3 reset alu_type", 64'(b3.alu_type_o), 64'(1));
    check("lat3 reset state", 64'(b3.state_dbg_o), 64'(0));

    // Directed single transactions.
    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Tie from reset, backpressure with the loser waiting, then a third tie.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    set_req(0, 1, 3'd2, 1, 9, 9);
    set_req(1, 1, 3'd3, 1, 3, 4);
    @(negedge clk);
    check("tie ready0", 64'(b1.req0_ready_o), 64'(1));
    check("tie ready1", 64'(b1.req1_ready_o), 64'(0));
    @(posedge clk); #1 set_req(0, 0, 3'd2, 1, 9, 9);
    n = 0;
    do begin
      @(negedge clk); n++;
      check("loser ready while busy", 64'(b1.req1_ready_o), 64'(0));
    end while (!b1.resp_valid_o && n < 20);
    check("tie first id",   64'(b1.resp_id_o),   64'(0));
    check("tie first data", 64'(b1.resp_data_o), 64'(0));
    check("tie first zero", 64'(b1.resp_zero_o), 64'(1));
    repeat (2) begin
      @(negedge clk);
      check("bp loser ready", 64'(b1.req1_ready_o), 64'(0));
      check("bp held zero",   64'(b1.resp_zero_o),  64'(1));
    end
    @(posedge clk); #1 b1.resp_ready_i = 1'b1;
    @(negedge clk);
    check("loser ready at handshake", 64'(b1.req1_ready_o), 64'(0));
    @(posedge clk); #1 b1.resp_ready_i = 1'b0;
    @(negedge clk);
    check("loser granted first idle", 64'(b1.req1_ready_o), 64'(1));
    @(posedge clk); #1 set_req(1, 0, 3'd3, 1, 3, 4);
    b1.resp_ready_i = 1'b1;
    wait_valid1(n);
    check("tie second id",   64'(b1.resp_id_o),   64'(1));
    check("tie second data", 64'(b1.resp_data_o), 64'(12));
    @(posedge clk); #1;
    set_req(0, 1, 3'd1, 1, 1, 1);
    set_req(1, 1, 3'd1, 1, 2, 2);
    @(negedge clk);
    check("third tie ready0", 64'(b1.req0_ready_o), 64'(1));
    check("third tie ready1", 64'(b1.req1_ready_o), 64'(0));
    @(posedge clk); #1;
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    n = 0;
    do begin @(negedge clk); n++; end while (b1.busy_o && n < 20);
    check("drain busy", 64'(b1.busy_o), 64'(0));

    // Reset while in EXEC: result discarded, no response.
    @(posedge clk); #1 set_req(0, 1, 3'd1, 1, 1, 1);
    b1.resp_ready_i = 1'b1;
    @(negedge clk);
    check("pre-reset grant", 64'(b1.req0_ready_o), 64'(1));
    @(posedge clk); #1 set_req(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_reset_vals("mid-exec reset");
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (b1.resp_valid_o) n++;
    end
    check("no response after reset", 64'(n), 64'(0));
    run_vec('{1, 3'd1, 1, 2, 3, 1, 32'd5, 0, 0});

    // Slow ALU instance.
    for (int k = 0; k < 2; k++) begin
      logic [W-1:0] exp_d;
      @(posedge clk); #1;
      b3.resp_ready_i = 1'b1;
      if (k == 0) begin
        b3.req0_valid_i = 1; b3.req0_op_i = 3'd1; b3.req0_type_i = 0;
        b3.req0_data1_i = 100; b3.req0_data2_i = 23;
        exp_d = 32'h8000_007B;
      end else begin
        b3.req1_valid_i = 1; b3.req1_op_i = 3'd3; b3.req1_type_i = 1;
        b3.req1_data1_i = 6; b3.req1_data2_i = 7;
        exp_d = 32'd42;
      end
      @(negedge clk);
      check("lat3 grant", 64'(k == 0 ? b3.req0_ready_o : b3.req1_ready_o), 64'(1));
      @(posedge clk); #1 b3.req0_valid_i = 0; b3.req1_valid_i = 0;
      n = 0;
      do begin
        @(negedge clk); n++;
        if (n == 1) begin
          check("lat3 alu_type", 64'(b3.alu_type_o), 64'(k == 0 ? 0 : 1));
          check("lat3 alu_ctrl", 64'(b3.alu_ctrl_o), 64'(k == 0 ? 1 : 3));
        end
      end while (!b3.resp_valid_o && n < 20);
      check("lat3 latency", 64'(n), 64'(LAT3 + 2));
      check("lat3 data",    64'(b3.resp_data_o), 64'(exp_d));
      check("lat3 id",      64'(b3.resp_id_o),   64'(k));
      @(negedge clk);
      check("lat3 idle after", 64'(b3.busy_o), 64'(0));
    end

    // Random traffic against a transaction-level model.
    @(posedge clk); #1 rst = 1'b1;
    b1.resp_ready_i = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    idle = 1; last = 1; vcyc = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bit e0;
      bit e1;
      @(posedge clk); #1;
      for (int r = 0; r < 2; r++) begin
        logic [2:0] op;
        logic [W-1:0] b;
        op = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 4));
        b  = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(0, 255));
        set_req(r[0], 1'($urandom_range(0, 1)), op, 1'($urandom_range(0, 1)),
                W'($urandom_range(0, 255)), b);
      end
      b1.resp_ready_i = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      e0 = idle && b1.req0_valid_i && (!b1.req1_valid_i || last);
      e1 = idle && b1.req1_valid_i && (!b1.req0_valid_i || !last);
      check("rnd ready0", 64'(b1.req0_ready_o), 64'(e0));
      check("rnd ready1", 64'(b1.req1_ready_o), 64'(e1));
      check("rnd busy",   64'(b1.busy_o),       64'(!idle));
      check("rnd valid",  64'(b1.resp_valid_o), 64'(!idle && cyc >= vcyc));
      if (b1.resp_valid_o && exp_q.size() > 0)
        check("rnd resp", 64'({b1.resp_id_o, b1.resp_err_o, b1.resp_zero_o, b1.resp_data_o}), 64'(exp_q[0]));
      if (!idle && cyc >= vcyc && b1.resp_ready_i) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        idle = 1;
      end else if (e0 || e1) begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        bit           typ;
        bit           rej;
        a   = e1 ? b1.req1_data1_i : b1.req0_data1_i;
        b   = e1 ? b1.req1_data2_i : b1.req0_data2_i;
        op  = e1 ? b1.req1_op_i    : b1.req0_op_i;
        typ = e1 ? b1.req1_type_i  : b1.req0_type_i;
        rej = (op < 1) || (op > 4) || (typ && op == 4 && b == 0);
        if (rej) exp_q.push_back({e1, 1'b1, 1'b0, {W{1'b0}}});
        else     exp_q.push_back({e1, 1'b0, alu_f(a, b, op, typ) == '0, alu_f(a, b, op, typ)});
        idle = 0;
        last = e1;
        vcyc = cyc + (rej ? 1 : LAT1 + 2);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares one ALU instance between two requesters using a round-robin policy.
- Registers and launches operands, waits a fixed number of ALU clock edges, captures the result, and returns it on a single response channel tagged with the requester ID.
- Screens out illegal opcodes and integer divide-by-zero before they reach the ALU.
- Sits between the core's execute-stage requesters and the ALU; only one operation is in flight at a time.

Parameters:
- ALU_LAT, 1: rising edges the ALU needs to update its data output after its inputs become stable (must be ≥1).
- W, 32: operand and result width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- req0_valid_i  in  1  requester 0 has an operation
- req0_ready_o  out  1  requester 0 accepted this cycle
- req0_data1_i  in  W  operand A
- req0_data2_i  in  W  operand B
- req0_op_i  in  3  1=SUM, 2=SUB, 3=MUL, 4=DIV
- req0_type_i  in  1  0=FPU, 1=integer
- req1_*  same set as req0_*, for requester 1
- alu_data1_o  out  W  to ALU data1
- alu_data2_o  out  W  to ALU data2
- alu_ctrl_o  out  3  to ALU opcode
- alu_type_o  out  1  to ALU type select
- alu_data_i  in  W  ALU result
- alu_zero_i  in  1  ALU zero flag
- resp_valid_o  out  1  response available
- resp_ready_i  in  1  consumer takes response
- resp_id_o  out  1  requester that owns the response
- resp_data_o  out  W  result
- resp_zero_o  out  1  captured zero flag
- resp_err_o  out  1  op rejected (illegal opcode or integer DIV by 0)
- busy_o  out  1  state != IDLE

Behaviour:
- States: IDLE, EXEC, RESP.
- Reset values:
  - state=IDLE, last_grant=1 (so req0 wins the first tie), cnt=0.
  - alu_data1_o=0, alu_data2_o=0, alu_ctrl_o=0 (no-op code; the ALU holds its output), alu_type_o=1.
  - resp_valid_o=0, resp_id_o=0, resp_data_o=0, resp_zero_o=0, resp_err_o=0.
- Arbitration (combinational, IDLE only):
  - If only one requester is valid, grant it.
  - If both are valid, grant the one that is not last_grant.
  - reqN_ready_o = (state==IDLE) & grantN. Ready is never high outside IDLE. Handshake occurs when valid & ready.
- Accept edge, legal op:
  - Latch the granted operands, op and type into alu_*_o.
  - Set resp_id_o and last_grant to the granted ID.
  - cnt <= ALU_LAT+1; state <= EXEC.
- Accept edge, rejected op (op not in 1..4, or type=1 & op=4 & data2==0):
  - Leave alu_*_o unchanged.
  - resp_data_o=0, resp_zero_o=0, resp_err_o=1, update resp_id_o and last_grant; state <= RESP.
- EXEC:
  - cnt decrements on each edge.
  - On the edge where cnt==1: resp_data_o <= alu_data_i, resp_zero_o <= alu_zero_i, resp_err_o <= 0, alu_ctrl_o <= 0, state <= RESP.
  - With ALU_LAT=1, resp_valid_o rises 2 cycles after the accept edge.
- RESP:
  - resp_valid_o=1.
  - All resp_* outputs are held stable until resp_valid_o & resp_ready_i; on that edge state <= IDLE and resp_valid_o <= 0.
  - No new grant is made in the same cycle, so the minimum back-to-back issue spacing is ALU_LAT+3 cycles.
- Requester inputs are ignored outside the accept cycle; a requester may change or drop valid while not ready.
- Reset asserted in any state, including mid-EXEC: return to reset values on that edge. The in-flight result is discarded and no response is issued for it.
- resp_ready_i is ignored outside RESP.
- No width growth: result is truncated to W, exactly as produced by the ALU.

Test Plan:
- Integer SUM on req0 (data1=5, data2=7), resp_ready_i=1 → req0_ready_o high 1 cycle, alu_ctrl_o=1, alu_type_o=1; 2 cycles later resp_valid_o=1, resp_id_o=0, resp_data_o=12, resp_err_o=0; busy_o low the next cycle.
- req0 and req1 both valid from reset (req0 SUB 9-9, req1 MUL 3*4) → req0 served first with resp_zero_o=1, resp_data_o=0; then req1 with resp_data_o=12, resp_id_o=1; a third tie then grants req0.
- Backpressure: req0 integer DIV 20/4 with resp_ready_i low for 3 cycles → resp_data_o=5 held stable all 3 cycles; req1 valid throughout but req1_ready_o stays 0; req1 is granted only in the first IDLE cycle after the response handshake.
- Integer DIV 8/0 on req1 → no EXEC and alu_ctrl_o stays 0; the cycle after accept, resp_valid_o=1, resp_err_o=1, resp_data_o=0, resp_id_o=1. Repeat with op=5 → same error response.
- Reset pulse one cycle after accepting req0 SUM 1+1 (in EXEC) → next cycle all outputs at reset values; resp_valid_o never asserts for that op; a following req1 op completes normally.
- FPU op (type=0, op=1) with ALU_LAT=3 → alu_type_o=0; resp_valid_o rises exactly 4 cycles after the accept edge with resp_data_o equal to the ALU output present at that capture edge.
